// File: rtl/byte_mem.sv
// byte_mem: single-port byte-enabled word memory behind a valid/ready request/response FSM.
// Revision: 1.0 -- optional BYTE_MEM_ALIGN_CHECK_EN rejects lane-misaligned accesses with rsp_err.
`timescale 1ns/1ps
`default_nettype none

module byte_mem #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int WORDS = 2 ** (ADDR_BITS - 2);
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ready_q;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0]          mem [WORDS];
  logic [ADDR_BITS-3:0] word;
  logic [31:0]          rd_word;
  logic                 accept;
  logic                 misaligned;
  logic                 do_write;

  // Upper address bits wrap away; the byte offset only matters to the alignment check.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:ADDR_BITS], req_addr[1:0]};

  assign word      = req_addr[ADDR_BITS-1:2];
  assign rd_word   = mem[word];
  assign req_ready = ready_q && (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign accept    = req_valid && req_ready;
  assign do_write  = accept && req_we && !misaligned;

`ifdef BYTE_MEM_ALIGN_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    misaligned = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (req_be[k] && ((k + int'(req_addr[1:0])) > 3)) misaligned = 1'b1;
    end
  end

  always_comb begin
    err_d = err_q;
    if (accept) err_d = misaligned;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign rsp_err = err_q;
`else
  assign misaligned = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  // Read data is captured on the acceptance edge; unselected lanes and writes return zero.
  always_comb begin
    rdata_d = rdata_q;
    if (accept) begin
      for (int k = 0; k < 4; k++) begin
        rdata_d[8*k +: 8] = (!req_we && !misaligned && req_be[k]) ? rd_word[8*k +: 8] : 8'h00;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= 1'b1;
      rdata_q <= rdata_d;
    end
  end

  // Storage has no reset so committed writes survive a later reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int k = 0; k < 4; k++) begin
        if (req_be[k]) mem[word][8*k +: 8] <= req_wdata[8*k +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_byte_mem.sv
// tb_byte_mem: directed self-checking bench for byte_mem (ADDR_BITS=10, WAIT_STATES=1).
`timescale 1ns/1ps
`default_nettype none

module tb_byte_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  byte_mem #(.ADDR_BITS(10), .WAIT_STATES(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_be    (req_be),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // One transaction with rsp_ready held high; lat = edges from acceptance to handshake.
  task automatic xact(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic err, output int lat);
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk);
  endtask

  // Accept a request, then pull reset while it sits in WAIT.
  task automatic reset_in_wait(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_we = we; req_be = 4'hF; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstwait_valid", 32'(rsp_valid), 32'd0);
    end
    check("rstwait_ready_low", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1 check("rel_ready_before_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rel_ready_after_edge", 32'(req_ready), 32'd1);
    check("rel_valid", 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] exp10;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    #1 check("ready_pre_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_post_edge", 32'(req_ready), 32'd1);

    // Full-word write then read with latency
    xact(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat);
    check("wr_rdata_zero", rd, 32'd0);
    check("wr_err", 32'(er), 32'd0);
    check("wr_lat", 32'(lat), 32'd2);
    xact(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
    check("rd_full", rd, 32'hDEADBEEF);
    check("rd_err", 32'(er), 32'd0);
    check("rd_lat", 32'(lat), 32'd2);

    // Partial byte write and lane-masked read
    xact(1'b1, 4'h1, 32'h10, 32'h000000AA, rd, er, lat);
    xact(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
    check("rd_after_b0", rd, 32'hDEADBEAA);
    xact(1'b0, 4'h6, 32'h10, 32'h0, rd, er, lat);
    check("rd_be6", rd, 32'h00ADBE00);
    exp10 = 32'hDEADBEAA;

    // Address wrap modulo 1 KiB
    xact(1'b1, 4'hF, 32'h400, 32'h12345678, rd, er, lat);
    xact(1'b0, 4'hF, 32'h000, 32'h0, rd, er, lat);
    check("wrap", rd, 32'h12345678);

    // Response back-pressure with req_* churning
    @(negedge clk);
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF; req_addr = 32'h10; rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b1; req_wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 4 && !rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, exp10);
      check("bp_ready", 32'(req_ready), 32'd0);
      req_addr = 32'(i * 4) + 32'h10 * 32'(i[0]);
      req_be   = 4'(i + 11);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    xact(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
    check("bp_no_write_10", rd, exp10);
    xact(1'b0, 4'hF, 32'h0, 32'h0, rd, er, lat);
    check("bp_no_write_0", rd, 32'h12345678);

    // Byte-offset write 0x13 be=0x3
    xact(1'b1, 4'h3, 32'h13, 32'h0000CAFE, rd, er, lat);
`ifdef BYTE_MEM_ALIGN_CHECK_EN
    check("misalign_err", 32'(er), 32'd1);
`else
    check("misalign_err", 32'(er), 32'd0);
    exp10 = 32'hDEADCAFE;
`endif
    check("misalign_lat", 32'(lat), 32'd2);
    xact(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
    check("after_0x13", rd, exp10);

    // Zero byte-enable accesses are no-ops that still respond
    xact(1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
    check("be0_rd", rd, 32'd0);
    check("be0_lat", 32'(lat), 32'd2);
    xact(1'b1, 4'h0, 32'h10, 32'h0, rd, er, lat);
    xact(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
    check("be0_wr_nochange", rd, exp10);

    // Reset during WAIT: read aborted, committed write kept
    reset_in_wait(1'b0, 32'h10, 32'h0);
    xact(1'b0, 4'hF, 32'h10, 32'h0, rd, er, lat);
    check("post_rst_rd", rd, exp10);
    reset_in_wait(1'b1, 32'h20, 32'h11223344);
    xact(1'b0, 4'hF, 32'h20, 32'h0, rd, er, lat);
    check("committed_wr", rd, 32'h11223344);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
